// File: rtl/cms_pix28_package.sv
// Shared FSM encoding and cfg_delay field layout for the CMS pixel-28 bxclk generator.
package cms_pix28_package;

    typedef enum logic [1:0] {
        IDLE_BXG  = 2'd0,
        RUN_BXG   = 2'd1,
        DRAIN_BXG = 2'd2,
        DONE_BXG  = 2'd3
    } state_t_sm_bxclk_gen;

    // Field layout of cfg_delay for the default two-channel, 5-bit build.
    localparam int BXG_DELAY_W_DEF   = 5;
    localparam int BXG_CH0_DELAY_LSB = 0;
    localparam int BXG_CH1_DELAY_LSB = BXG_DELAY_W_DEF;

    // LSB of channel ch's delay field for any DELAY_W.
    function automatic int delay_lsb(input int ch, input int delay_w);
        return ch * delay_w;
    endfunction

endpackage

// File: rtl/cms_pix28_bxclk_phase.sv
// One phase-shifted bxclk channel: decides from the shared period counter whether this
// channel is high, and registers the result so the output is a clean flop.
module cms_pix28_bxclk_phase
    import cms_pix28_package::*;
#(
    parameter int PERIOD_W = 6,
    parameter int DELAY_W  = 5
) (
    input  logic                fw_pl_clk1,
    input  logic                fw_rst,
    input  logic                active,
    input  logic [PERIOD_W-1:0] cnt,
    input  logic [PERIOD_W-1:0] period,
    input  logic [PERIOD_W-1:0] half,
    input  logic [DELAY_W-1:0]  delay,
    input  logic                sign,
    output logic                bxclk
);

    // One spare bit keeps cnt + period and cnt + delay from overflowing.
    localparam int AW = PERIOD_W + 1;

    logic [AW-1:0] cnt_x;
    logic [AW-1:0] per_x;
    logic [AW-1:0] half_x;
    logic [AW-1:0] dly_x;
    logic [AW-1:0] pos;

    // NOTE: every variable assigned in always_comb gets a value on every path first,
    // otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        cnt_x  = AW'(cnt);
        per_x  = AW'(period);
        half_x = AW'(half);
        dly_x  = AW'(delay);
        pos    = '0;
        if (sign) begin
            pos = cnt_x + dly_x;
            if (pos >= per_x) begin
                pos = pos - per_x;
            end
        end else if (cnt_x >= dly_x) begin
            pos = cnt_x - dly_x;
        end else begin
            pos = cnt_x + per_x - dly_x;
        end
    end

    // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge fw_pl_clk1) begin
        if (fw_rst) begin
            bxclk <= 1'b0;
        end else begin
            bxclk <= active && (pos < half_x);
        end
    end

endmodule

// File: rtl/cms_pix28_bxclk_gen.sv
// Multi-channel bunch-crossing clock generator (burst or free-running, per-channel phase).
// Per-channel delay/sign is enabled by defining CMS_PIX28_BXCLK_PHASE_ADJ_EN.
module cms_pix28_bxclk_gen
    import cms_pix28_package::*;
#(
    parameter int PERIOD_W = 6,
    parameter int DELAY_W  = 5,
    parameter int N_CH     = 2,
    parameter int BURST_W  = 16
) (
    input  logic                      fw_pl_clk1,
    input  logic                      fw_rst,
    input  logic                      start,
    input  logic                      stop,
    input  logic [PERIOD_W-1:0]       cfg_period,
    input  logic [N_CH*DELAY_W-1:0]   cfg_delay,
    input  logic [N_CH-1:0]           cfg_delay_sign,
    input  logic [BURST_W-1:0]        cfg_burst_len,
    output logic                      busy,
    output logic                      bxclk_ana,
    output logic [N_CH-1:0]           bxclk,
    output logic                      bx_tick,
    output logic                      burst_done,
    output logic                      cfg_err
);

    localparam int CW = (PERIOD_W > DELAY_W) ? PERIOD_W : DELAY_W;

    state_t_sm_bxclk_gen state;

    logic [PERIOD_W-1:0] cnt;
    logic [PERIOD_W-1:0] period_q;
    logic [PERIOD_W-1:0] half_q;
    logic [BURST_W-1:0]  burst_q;
    logic [BURST_W-1:0]  pcnt;
    logic [DELAY_W-1:0]  delay_q [N_CH];
    logic [N_CH-1:0]     sign_q;
    logic                err_q;
    logic                ana_q;
    logic                tick_q;

    logic                active;
    logic                wrap;
    logic                burst_hit;
    logic                start_ok;
    logic                start_bad;
    logic [PERIOD_W-1:0] half_in;
    logic [DELAY_W-1:0]  delay_in [N_CH];
    logic [N_CH-1:0]     sign_in;
    logic [N_CH-1:0]     clamp;

    assign active    = (state == RUN_BXG) || (state == DRAIN_BXG);
    assign wrap      = (cnt == period_q - PERIOD_W'(1));
    assign burst_hit = (burst_q != '0) && ((pcnt + BURST_W'(1)) == burst_q);
    assign start_ok  = (state == IDLE_BXG) && start && !stop && (cfg_period >= PERIOD_W'(2));
    assign start_bad = (state == IDLE_BXG) && start && !stop && (cfg_period <  PERIOD_W'(2));
    assign half_in   = cfg_period >> 1;

    // Delay values as they will be latched at start, clamped to half a period.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            delay_in[i] = '0;
        end
        sign_in = '0;
        clamp   = '0;
`ifdef CMS_PIX28_BXCLK_PHASE_ADJ_EN
        for (int i = 0; i < N_CH; i++) begin
            if (CW'(cfg_delay[delay_lsb(i, DELAY_W) +: DELAY_W]) > CW'(half_in)) begin
                delay_in[i] = DELAY_W'(half_in);
                clamp[i]    = 1'b1;
            end else begin
                delay_in[i] = cfg_delay[delay_lsb(i, DELAY_W) +: DELAY_W];
            end
        end
        sign_in = cfg_delay_sign;
`endif
    end

`ifndef CMS_PIX28_BXCLK_PHASE_ADJ_EN
    // Without phase adjust every channel follows bxclk_ana; the delay inputs are dead.
    logic unused_phase_cfg;
    assign unused_phase_cfg = ^{cfg_delay, cfg_delay_sign};
`endif

    always_ff @(posedge fw_pl_clk1) begin
        if (fw_rst) begin
            state    <= IDLE_BXG;
            cnt      <= '0;
            pcnt     <= '0;
            period_q <= '0;
            half_q   <= '0;
            burst_q  <= '0;
            sign_q   <= '0;
            err_q    <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                delay_q[i] <= '0;
            end
        end else begin
            unique case (state)
                IDLE_BXG: begin
                    if (start_ok) begin
                        state    <= RUN_BXG;
                        cnt      <= '0;
                        pcnt     <= '0;
                        period_q <= cfg_period;
                        half_q   <= half_in;
                        burst_q  <= cfg_burst_len;
                        sign_q   <= sign_in;
                        err_q    <= |clamp;
                        for (int i = 0; i < N_CH; i++) begin
                            delay_q[i] <= delay_in[i];
                        end
                    end else if (start_bad) begin
                        err_q <= 1'b1;
                    end
                end
                RUN_BXG: begin
                    cnt <= wrap ? '0 : cnt + PERIOD_W'(1);
                    if (wrap) begin
                        pcnt <= pcnt + BURST_W'(1);
                    end
                    // A stop landing on the last cycle of a period ends the run right there.
                    if (wrap && (stop || burst_hit)) begin
                        state <= DONE_BXG;
                    end else if (stop) begin
                        state <= DRAIN_BXG;
                    end
                end
                DRAIN_BXG: begin
                    cnt <= wrap ? '0 : cnt + PERIOD_W'(1);
                    if (wrap) begin
                        state <= DONE_BXG;
                    end
                end
                DONE_BXG: begin
                    state <= IDLE_BXG;
                    cnt   <= '0;
                end
                default: state <= IDLE_BXG;
            endcase
        end
    end

    always_ff @(posedge fw_pl_clk1) begin
        if (fw_rst) begin
            ana_q  <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            ana_q  <= active && (cnt < half_q);
            tick_q <= active && (cnt == '0);
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        cms_pix28_bxclk_phase #(
            .PERIOD_W (PERIOD_W),
            .DELAY_W  (DELAY_W)
        ) u_phase (
            .fw_pl_clk1 (fw_pl_clk1),
            .fw_rst     (fw_rst),
            .active     (active),
            .cnt        (cnt),
            .period     (period_q),
            .half       (half_q),
            .delay      (delay_q[g]),
            .sign       (sign_q[g]),
            .bxclk      (bxclk[g])
        );
    end

    assign busy       = active;
    assign burst_done = (state == DONE_BXG);
    assign bxclk_ana  = ana_q;
    assign bx_tick    = tick_q;
    assign cfg_err    = err_q;

endmodule

// File: tb/tb_cms_pix28_bxclk_gen.sv
// Scoreboard bench for cms_pix28_bxclk_gen; expectations follow CMS_PIX28_BXCLK_PHASE_ADJ_EN.
module tb_cms_pix28_bxclk_gen;

    localparam int PERIOD_W = 6;
    localparam int DELAY_W  = 5;
    localparam int N_CH     = 2;
    localparam int BURST_W  = 16;

    typedef struct packed {
        logic            busy;
        logic            ana;
        logic [N_CH-1:0] bx;
        logic            tick;
        logic            done;
        logic            err;
    } exp_t;

    logic                    fw_pl_clk1 = 1'b0;
    logic                    fw_rst = 1'b1;
    logic                    start = 1'b0;
    logic                    stop = 1'b0;
    logic [PERIOD_W-1:0]     cfg_period = '0;
    logic [N_CH*DELAY_W-1:0] cfg_delay = '0;
    logic [N_CH-1:0]         cfg_delay_sign = '0;
    logic [BURST_W-1:0]      cfg_burst_len = '0;
    logic                    busy;
    logic                    bxclk_ana;
    logic [N_CH-1:0]         bxclk;
    logic                    bx_tick;
    logic                    burst_done;
    logic                    cfg_err;

    exp_t sb[$];
    exp_t obs;
    exp_t exp_v;
    int   errors = 0;
    int   checks = 0;

    always #5 fw_pl_clk1 = ~fw_pl_clk1;

    cms_pix28_bxclk_gen #(
        .PERIOD_W (PERIOD_W),
        .DELAY_W  (DELAY_W),
        .N_CH     (N_CH),
        .BURST_W  (BURST_W)
    ) dut (
        .fw_pl_clk1     (fw_pl_clk1),
        .fw_rst         (fw_rst),
        .start          (start),
        .stop           (stop),
        .cfg_period     (cfg_period),
        .cfg_delay      (cfg_delay),
        .cfg_delay_sign (cfg_delay_sign),
        .cfg_burst_len  (cfg_burst_len),
        .busy           (busy),
        .bxclk_ana      (bxclk_ana),
        .bxclk          (bxclk),
        .bx_tick        (bx_tick),
        .burst_done     (burst_done),
        .cfg_err        (cfg_err)
    );

    assign obs = {busy, bxclk_ana, bxclk, bx_tick, burst_done, cfg_err};

    // Level of one channel given the in-period position c (0..p-1).
    function automatic logic phase_exp(int c, int p, int d, int s);
        int h;
        int dd;
        h = p / 2;
`ifdef CMS_PIX28_BXCLK_PHASE_ADJ_EN
        dd = (d > h) ? h : d;
        if (s != 0) return ((c + dd) % p) < h;
        return ((c - dd + p) % p) < h;
`else
        dd = d * 0 + s * 0;
        return (c + dd) < h;
`endif
    endfunction

    function automatic logic clamp_err(int p, int d0, int d1);
`ifdef CMS_PIX28_BXCLK_PHASE_ADJ_EN
        return (d0 > p / 2) || (d1 > p / 2);
`else
        return (d0 + d1 + p) < 0;
`endif
    endfunction

    // Outputs at cycle k after a start in cycle 0; the last counted cycle of the run is e
    // (e<0: start rejected), and from cycle cut on the block is held in reset.
    function automatic exp_t model(int k, int p, int d0, int s0, int d1, int s1,
                                   int e, int cut, logic err);
        exp_t x;
        int   c;
        x = '0;
        if (k >= cut) return x;
        x.err = err;
        if (e < 0) return x;
        x.busy = (k >= 1) && (k <= e);
        x.done = (k == e + 1);
        if (k >= 2 && k <= e + 1) begin
            c        = (k - 2) % p;
            x.ana    = c < p / 2;
            x.tick   = (c == 0);
            x.bx[0]  = phase_exp(c, p, d0, s0);
            x.bx[1]  = phase_exp(c, p, d1, s1);
        end
        return x;
    endfunction

    task automatic start_run(int p, int d0, int s0, int d1, int s1, int burst, int with_stop,
                             int n, int e, int cut, logic err);
        @(posedge fw_pl_clk1);
        #1;
        cfg_period     = PERIOD_W'(p);
        cfg_delay      = {DELAY_W'(d1), DELAY_W'(d0)};
        cfg_delay_sign = {1'(s1), 1'(s0)};
        cfg_burst_len  = BURST_W'(burst);
        start          = 1'b1;
        stop           = (with_stop != 0);
        for (int k = 1; k <= n; k++) begin
            sb.push_back(model(k, p, d0, s0, d1, s1, e, cut, err));
        end
    endtask

    task automatic step(int k, int stop_at, int rst_at, int chg_at);
        @(posedge fw_pl_clk1);
        #1;
        start  = 1'b0;
        stop   = (k == stop_at);
        fw_rst = (k == rst_at);
        if (k == chg_at) begin
            cfg_period     = PERIOD_W'(3);
            cfg_delay      = '1;
            cfg_delay_sign = '0;
            cfg_burst_len  = BURST_W'(1);
            start          = 1'b1;
        end
        @(negedge fw_pl_clk1);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge fw_pl_clk1);
            exp_v = '0;
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL reset cycle %0d: got %b expected %b", i, obs, exp_v);
            end
        end
        @(posedge fw_pl_clk1);
        #1;
        fw_rst = 1'b0;
    endtask

    task automatic test_burst();
        start_run(10, 2, 0, 2, 1, 3, 0, 33, 30, 1000, clamp_err(10, 2, 2));
        for (int k = 1; k <= 33; k++) begin
            step(k, -1, -1, -1);
            exp_v = sb.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL burst cycle %0d: got %b expected %b (busy,ana,bx,tick,done,err)", k, obs, exp_v);
            end
        end
    endtask

    task automatic test_stop();
        start_run(4, 0, 0, 0, 0, 0, 0, 16, 12, 1000, 1'b0);
        for (int k = 1; k <= 16; k++) begin
            step(k, 9, -1, -1);
            exp_v = sb.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL stop cycle %0d: got %b expected %b (busy,ana,bx,tick,done,err)", k, obs, exp_v);
            end
        end
    endtask

    task automatic test_bad_period();
        start_run(1, 0, 0, 0, 0, 1, 0, 6, -1, 1000, 1'b1);
        for (int k = 1; k <= 6; k++) begin
            step(k, -1, -1, -1);
            exp_v = sb.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL bad_period cycle %0d: got %b expected %b", k, obs, exp_v);
            end
        end
        start_run(8, 0, 0, 0, 0, 1, 0, 11, 8, 1000, 1'b0);
        for (int k = 1; k <= 11; k++) begin
            step(k, -1, -1, -1);
            exp_v = sb.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL err_clear cycle %0d: got %b expected %b", k, obs, exp_v);
            end
        end
    endtask

    task automatic test_clamp();
        start_run(8, 7, 0, 0, 0, 2, 0, 19, 16, 1000, clamp_err(8, 7, 0));
        for (int k = 1; k <= 19; k++) begin
            step(k, -1, -1, -1);
            exp_v = sb.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL clamp cycle %0d: got %b expected %b", k, obs, exp_v);
            end
        end
    endtask

    task automatic test_cfg_change();
        start_run(6, 1, 0, 1, 1, 2, 0, 15, 12, 1000, clamp_err(6, 1, 1));
        for (int k = 1; k <= 15; k++) begin
            step(k, -1, -1, 3);
            exp_v = sb.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL cfg_change cycle %0d: got %b expected %b", k, obs, exp_v);
            end
        end
    endtask

    task automatic test_start_stop();
        start_run(8, 0, 0, 0, 0, 1, 1, 10, -1, 1000, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            step(k, -1, -1, -1);
            exp_v = sb.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL start_stop cycle %0d: got %b expected %b", k, obs, exp_v);
            end
        end
    endtask

    task automatic test_reset_mid();
        start_run(10, 3, 1, 1, 0, 0, 0, 20, 1000, 16, clamp_err(10, 3, 1));
        for (int k = 1; k <= 20; k++) begin
            step(k, -1, 15, -1);
            exp_v = sb.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL reset_mid cycle %0d: got %b expected %b", k, obs, exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_burst();
        test_stop();
        test_bad_period();
        test_clamp();
        test_cfg_change();
        test_start_stop();
        test_reset_mid();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cms_pix28_bxclk_gen.md
# cms_pix28_bxclk_gen

Parametrised multi-channel bunch-crossing clock generator for the CMS pixel-28 test firmware. It derives one undelayed reference clock and N_CH independently phase-shifted bxclk outputs from fw_pl_clk1. Each output runs either as a burst of a programmed number of periods or free-running. It is the successor to the single-channel bxclk period/delay/sign logic used by the IP2 tests, and it is driven by the IP2 test state machines in place of that logic.

## Interface
- PERIOD_W, 6: width of the period field, in fw_pl_clk1 cycles.
- DELAY_W, 5: width of each per-channel delay field.
- N_CH, 2: number of delayed bxclk channels (≥1).
- BURST_W, 16: width of the burst-length field.
- fw_pl_clk1  in  1  sole clock. All logic is on the rising edge.
- fw_rst  in  1  reset, synchronous and active-high.
- start  in  1  one-cycle request to begin generating. Sampled only in IDLE.
- stop  in  1  one-cycle request to end the run after the current period completes.
- cfg_period  in  PERIOD_W  period P, in fw_pl_clk1 cycles.
- cfg_delay  in  N_CH*DELAY_W  per-channel delay d[i]; channel i occupies bits [i*DELAY_W +: DELAY_W].
- cfg_delay_sign  in  N_CH  per channel: 0 = retard by d, 1 = advance by d.
- cfg_burst_len  in  BURST_W  number of periods to generate; 0 = free-running.
- busy  out  1  high while in RUN or DRAIN.
- bxclk_ana  out  1  undelayed reference clock.
- bxclk  out  N_CH  phase-shifted clocks.
- bx_tick  out  1  one-cycle pulse coincident with the first high cycle of bxclk_ana in each period.
- burst_done  out  1  one-cycle pulse when a run ends.
- cfg_err  out  1  sticky error flag; cleared by fw_rst or by an accepted start.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start && !stop && P≥2: latch all cfg_* inputs, cnt←0, period counter←0, go to RUN.
  - start with P<2: set cfg_err, stay in IDLE.
  - start and stop together: stay in IDLE, no other effect.
- RUN:
  - cnt counts 0..P−1 and wraps.
  - At each wrap (cnt==P−1) the period counter increments.
  - If cfg_burst_len≠0 and the period counter reaches cfg_burst_len, go to DONE.
  - stop: go to DRAIN.
  - start: ignored.
- DRAIN: continue counting until cnt==P−1, then go to DONE.
- DONE: assert burst_done for one cycle, then go to IDLE.
- Waveforms, with H = P>>1 (floor):
  - bxclk_ana = (cnt < H).
  - Channel i, sign 0: high when ((cnt − d[i]) mod P) < H.
  - Channel i, sign 1: high when ((cnt + d[i]) mod P) < H.
  - The mod-P arithmetic uses PERIOD_W+1 bits with no overflow.
- Delay clamp: if d[i] > H at start, use d[i]=H and set cfg_err; the run still proceeds.
- Outside RUN and DRAIN, all clocks and bx_tick are 0.
- Live cfg_* inputs are ignored while busy.

## Timing
- Reset values: busy, bxclk_ana, bxclk, bx_tick, burst_done and cfg_err are all 0; FSM is in IDLE; cnt=0.
- Start sequence, with start accepted at cycle t:
  - busy=1 and cnt=0 at t+1.
  - All clock outputs and bx_tick are registered from cnt, so the first bxclk_ana high and the first bx_tick appear at t+2.
- Last period ends at cycle e (cnt==P−1):
  - DONE and burst_done=1 at e+1.
  - busy=0 from e+1.
  - Clock outputs return to 0 at e+2.
- No clock output glitches: every clock output is driven directly from a flop.
- fw_rst asserted mid-run: all outputs are 0 on the next cycle, with no burst_done pulse.

## Configuration
- CMS_PIX28_BXCLK_PHASE_ADJ_EN:
  - Defined: per-channel delay and sign behave as specified above.
  - Undefined: cfg_delay and cfg_delay_sign are ignored, every bxclk[i] equals bxclk_ana, the delay clamp is removed, and cfg_err reflects only the P<2 check.

## Structure
- In cms_pix28_package:
  - enum state_t_sm_bxclk_gen (IDLE_BXG, RUN_BXG, DRAIN_BXG, DONE_BXG).
  - Localparams for the field indices of cfg_delay.
- Sub-module cms_pix28_bxclk_phase (one instance per channel): takes cnt, P, H, d and sign, and produces one registered clock bit.

## Test plan
- P=10, ch0 d=2 sign0, ch1 d=2 sign1, burst=3, start at cycle 0:
  - bxclk_ana high cycles 2–6, 12–16, 22–26.
  - ch0 high cycles 4–8; ch1 high cycles 0(n/a)–4 pattern, i.e. 2–4 and 10–14.
  - bx_tick at cycles 2, 12, 22; burst_done at 31; busy=0 at 31.
- burst=0, P=4, stop at cycle 9: the current period finishes, then exactly one burst_done.
- P=1, start: cfg_err=1, busy stays 0, no clock toggles. A following start with P=8 clears cfg_err and runs.
- P=8, d=7: cfg_err=1 and ch0 behaves as d=4, i.e. ch0 is the inverse of bxclk_ana.
- fw_rst at cycle 15 of a run: all outputs 0 at cycle 16, FSM in IDLE, no burst_done.
- Changing cfg_period during RUN does not alter the period; start and stop together in IDLE produce no activity.
